// File: rtl/channel_avgpool.sv
// Streaming per-channel average pooling over non-overlapping windows of POOL_LEN valid samples.
// Optional rounding (round half up, clamped to max) is enabled with `define CHANNEL_AVGPOOL_ROUND_EN.
module channel_avgpool #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int POOL_LEN   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_in [0:NUM_CH-1],
    input  logic                         x_valid,
    input  logic                         flush,
    output logic signed [DATA_WIDTH-1:0] y_out [0:NUM_CH-1],
    output logic                         y_valid,
    output logic                         win_busy
);

    localparam int LOG2_POOL = $clog2(POOL_LEN);
    localparam int CNT_W     = (LOG2_POOL > 0) ? LOG2_POOL : 1;
`ifdef CHANNEL_AVGPOOL_ROUND_EN
    // One guard bit keeps the rounding bias from wrapping a full-scale positive sum.
    localparam int ACC_W = DATA_WIDTH + LOG2_POOL + 1;
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'((2 ** LOG2_POOL) / 2);
    localparam logic signed [ACC_W-1:0] Y_MAX_EXT =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] Y_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
`else
    localparam int ACC_W = DATA_WIDTH + LOG2_POOL;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_LEN - 1);

    logic signed [ACC_W-1:0]      acc_q   [0:NUM_CH-1];
    logic signed [ACC_W-1:0]      acc_d   [0:NUM_CH-1];
    logic signed [ACC_W-1:0]      sum_w   [0:NUM_CH-1];
    logic signed [ACC_W-1:0]      shr_w   [0:NUM_CH-1];
    logic signed [DATA_WIDTH-1:0] y_cand  [0:NUM_CH-1];
    logic signed [DATA_WIDTH-1:0] y_q     [0:NUM_CH-1];
    logic signed [DATA_WIDTH-1:0] y_d     [0:NUM_CH-1];
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         y_valid_q, y_valid_d;
    logic                         busy_q, busy_d;
    logic                         last_w;

    assign last_w = (cnt_q == LAST_CNT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign sum_w[gi] = acc_q[gi] + ACC_W'(x_in[gi]);
`ifdef CHANNEL_AVGPOOL_ROUND_EN
            assign shr_w[gi]  = (sum_w[gi] + ROUND_BIAS) >>> LOG2_POOL;
            assign y_cand[gi] = (shr_w[gi] > Y_MAX_EXT) ? Y_MAX : DATA_WIDTH'(shr_w[gi]);
`else
            // Arithmetic shift floors toward -inf; the window mean always fits in DATA_WIDTH.
            assign shr_w[gi]  = sum_w[gi] >>> LOG2_POOL;
            assign y_cand[gi] = DATA_WIDTH'(shr_w[gi]);
`endif
        end
    endgenerate

    always_comb begin
        acc_d     = acc_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        y_valid_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        end else if (x_valid) begin
            if (last_w) begin
                y_d       = y_cand;
                y_valid_d = 1'b1;
                cnt_d     = '0;
                for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + 1'b1;
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                y_q[i]   <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
        end
    end

    assign y_out    = y_q;
    assign y_valid  = y_valid_q;
    assign win_busy = busy_q;

endmodule

// File: tb/tb_channel_avgpool.sv
// Self-checking bench for channel_avgpool: directed scenarios plus random traffic against a window-list model.
module tb_channel_avgpool;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int PL = 8;

    typedef int vec_t [NC];

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] x_in [0:NC-1];
    logic                 x_valid = 1'b0;
    logic                 flush = 1'b0;
    logic signed [DW-1:0] y_out [0:NC-1];
    logic                 y_valid;
    logic                 win_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: the samples of the open window and the last published result.
    vec_t win_q [$];
    vec_t y_m;
    bit   yv_m;

    channel_avgpool #(.DATA_WIDTH(DW), .NUM_CH(NC), .POOL_LEN(PL)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .flush(flush),
        .y_out(y_out), .y_valid(y_valid), .win_busy(win_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int window_mean(input int sum);
        int r;
`ifdef CHANNEL_AVGPOOL_ROUND_EN
        r = floor_div(sum + PL / 2, PL);
        if (r > 32767) r = 32767;
`else
        r = floor_div(sum, PL);
`endif
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < NC; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
        return v;
    endfunction

    function automatic vec_t splat(input int a);
        vec_t v;
        for (int i = 0; i < NC; i++) v[i] = a;
        return v;
    endfunction

    task automatic step(input bit r, input bit v, input bit f, input vec_t d);
        int s;
        rst = r; x_valid = v; flush = f;
        for (int i = 0; i < NC; i++) x_in[i] = DW'(d[i]);
        @(posedge clk);
        #1;
        cyc++;
        yv_m = 1'b0;
        if (r) begin
            win_q.delete();
            y_m = splat(0);
        end else if (f) begin
            win_q.delete();
        end else if (v) begin
            win_q.push_back(d);
            if (win_q.size() == PL) begin
                for (int c = 0; c < NC; c++) begin
                    s = 0;
                    foreach (win_q[k]) s += win_q[k][c];
                    y_m[c] = window_mean(s);
                end
                yv_m = 1'b1;
                win_q.delete();
            end
        end
        if (y_valid)
            $display("pulse cyc=%0d y=%0d %0d %0d %0d", cyc, y_out[0], y_out[1], y_out[2], y_out[3]);
        check("y_valid", int'(y_valid), int'(yv_m));
        check("win_busy", int'(win_busy), int'(win_q.size() != 0));
        for (int c = 0; c < NC; c++) check($sformatf("y_out%0d", c), int'(y_out[c]), y_m[c]);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, rnd_vec());
    endtask

    initial begin
        vec_t v;
        int   pulses;
        for (int i = 0; i < NC; i++) x_in[i] = '0;
        y_m = splat(0);

        // Reset held with live traffic, then one idle cycle after release.
        repeat (3) step(1'b1, 1'b1, 1'b0, rnd_vec());
        idle();

        // Basic average with full-scale channels.
        for (int k = 1; k <= PL; k++) begin
            v = '{k, -1, 32767, -32768};
            step(1'b0, 1'b1, 1'b0, v);
        end
`ifdef CHANNEL_AVGPOOL_ROUND_EN
        check("basic_ch0", int'(y_out[0]), 5);
`else
        check("basic_ch0", int'(y_out[0]), 4);
`endif
        check("basic_ch1", int'(y_out[1]), -1);
        check("basic_ch2", int'(y_out[2]), 32767);
        check("basic_ch3", int'(y_out[3]), -32768);
        check("basic_pulse", int'(y_valid), 1);
        idle();
        check("basic_pulse_drop", int'(y_valid), 0);

        // Same window with random gaps; count pulses independently.
        pulses = 0;
        for (int k = 1; k <= PL; k++) begin
            repeat ($urandom_range(0, 3)) begin
                idle();
                if (y_valid) pulses++;
            end
            v = '{k, -1, 32767, -32768};
            step(1'b0, 1'b1, 1'b0, v);
            if (y_valid) pulses++;
        end
        repeat (3) begin
            idle();
            if (y_valid) pulses++;
        end
        check("gapped_pulses", pulses, 1);

        // Flush discards the partial window and the coincident sample.
        repeat (5) step(1'b0, 1'b1, 1'b0, splat(100));
        step(1'b0, 1'b1, 1'b1, splat(100));
        repeat (PL) step(1'b0, 1'b1, 1'b0, splat(10));
        check("flush_result", int'(y_out[2]), 10);
        idle();

        // Reset mid-window.
        repeat (3) step(1'b0, 1'b1, 1'b0, splat(50));
        step(1'b1, 1'b0, 1'b0, splat(0));
        repeat (PL) step(1'b0, 1'b1, 1'b0, splat(2));
        check("rst_mid_result", int'(y_out[1]), 2);

        // Back-to-back windows.
        repeat (PL) step(1'b0, 1'b1, 1'b0, splat(7));
        check("b2b_first", int'(y_out[0]), 7);
        repeat (PL) step(1'b0, 1'b1, 1'b0, splat(-9));
        check("b2b_second", int'(y_out[3]), -9);
        idle();

        // Random traffic with occasional flushes and resets.
        repeat (600) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            step(sel == 0, sel < 75, (sel >= 1) && (sel < 4), rnd_vec());
        end
        repeat (2) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/channel_avgpool.md
Name: channel_avgpool

Overview:
- Streaming temporal average-pooling stage that sits directly downstream of the per-channel scaling stage in the conv datapath.
- Accepts one NUM_CH-wide vector per valid cycle and accumulates POOL_LEN consecutive valid vectors per channel (non-overlapping windows).
- Emits one averaged vector per window, reducing the sample rate by POOL_LEN before the next conv/attention stage.

Parameters:
- DATA_WIDTH, 16, width of input and output samples (signed).
- NUM_CH, 4, number of parallel channels.
- POOL_LEN, 8, window length in valid samples; must be a power of two, >= 1.
- LOG2_POOL, $clog2(POOL_LEN), derived; shift amount; not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- x_in  input  NUM_CH x DATA_WIDTH (signed, unpacked array [0:NUM_CH-1])  input vector.
- x_valid  input  1  x_in is valid this cycle.
- flush  input  1  discard the partial window and restart the count.
- y_out  output  NUM_CH x DATA_WIDTH (signed, unpacked array [0:NUM_CH-1])  pooled vector.
- y_valid  output  1  single-cycle pulse; y_out carries a new window result.
- win_busy  output  1  high while a partial window is held (sample count != 0).

Behaviour:
- Reset: clk and rst as stated; rst is synchronous, active-high. On reset, y_out = all 0, y_valid = 0, win_busy = 0, all accumulators = 0, sample count = 0.
- Accumulator per channel: signed, DATA_WIDTH+LOG2_POOL bits. Input is sign-extended before add. The sum can never overflow, so no saturation is needed.
- Counter cnt: LOG2_POOL bits (1 bit if POOL_LEN=1). Counts 0..POOL_LEN-1 and advances only on x_valid. Idle cycles (x_valid=0) hold all state; gaps of any length are allowed.
- States: ACCUM (cnt < POOL_LEN-1) and LAST (cnt == POOL_LEN-1). The state is implied by cnt; no separate FSM register.
- On x_valid with cnt != POOL_LEN-1: acc[i] <= acc[i] + x_in[i]; cnt++.
- On x_valid with cnt == POOL_LEN-1:
  - y_out[i] <= (acc[i] + x_in[i]) >>> LOG2_POOL, truncated to DATA_WIDTH bits. The result is always in range.
  - y_valid <= 1; acc <= 0; cnt <= 0.
- Latency: y_valid asserts exactly 1 cycle after the cycle carrying the POOL_LEN-th valid sample of the window.
- y_valid is 0 in every other cycle. y_out holds its last value between pulses.
- Back-to-back windows: a sample arriving in the same cycle as y_valid=1 is the first sample of the next window. No bubble is required.
- Default rounding: arithmetic shift, i.e. floor toward -inf.
- flush=1: acc <= 0, cnt <= 0, no output pulse. Flush has priority over x_valid; a sample in the same cycle is discarded. y_out is unchanged.
- win_busy = (cnt != 0), registered state, so it reflects the count after the last update.
- POOL_LEN=1: every valid sample passes through with 1-cycle latency; win_busy stays 0.
- Reset mid-window discards the partial window. The first window after reset starts with the first valid sample.

Optional Feature:
- Macro: CHANNEL_AVGPOOL_ROUND_EN.
- Defined: add 2^(LOG2_POOL-1) to the full sum before the shift (round half toward +inf). The accumulator gains 1 guard bit so this bias cannot overflow. The result is clamped to DATA_WIDTH signed max (e.g. all-32767 inputs stay 32767). For POOL_LEN=1 no bias is added.
- Undefined: plain floor shift, as described in Behaviour; no extra bits or clamp logic.

Test Plan:
All scenarios use DATA_WIDTH=16, NUM_CH=4, POOL_LEN=8.
1. Reset: hold rst for 3 cycles with x_valid=1 and random data -> y_valid=0, y_out all 0, win_busy=0 throughout and in the first cycle after release.
2. Basic average: 8 consecutive valid vectors with ch0=1..8, ch1=-1, ch2=32767, ch3=-32768.
   - Without macro -> one y_valid pulse, 1 cycle after the 8th sample, with {4, -1, 32767, -32768}.
   - With CHANNEL_AVGPOOL_ROUND_EN -> {5, -1, 32767, -32768}.
3. Gapped input: same 8 vectors with 0-3 random idle cycles between them -> identical result; exactly one pulse, 1 cycle after the 8th valid sample; win_busy high from after the 1st sample until after the 8th.
4. Flush: 5 samples of 100, then flush=1 together with x_valid=1 (data 100), then 8 samples of 10 -> no pulse for the partial window; a single pulse with all channels = 10.
5. Reset mid-window: 3 samples of 50, rst for 1 cycle, then 8 samples of 2 -> one pulse with all channels = 2.
6. Back-to-back: 16 continuous valid cycles, first 8 = 7, next 8 = -9 -> pulses 1 cycle after samples 8 and 16, values 7 and -9; each y_valid lasts exactly one cycle with no gap required between windows.
